// File: rtl/llc_txsched_if.sv
// Bundle of request, status and LLC handshake signals between the CPU
// register block / LLC FSM and the transmit scheduler.
interface llc_txsched_if #(
    parameter int NBUF = 4,
    parameter int TMOW = 16
);
    localparam int SELW = $clog2(NBUF);

    logic            initreqr;
    logic [NBUF-1:0] txreq;
    logic [NBUF-1:0] txabort;
    logic [TMOW-1:0] tmo_limit;
    logic            trans;
    logic            sucftranc;
    logic            traregbit;
    logic [SELW-1:0] selbuf;
    logic            selvalid;
    logic [NBUF-1:0] txpend;
    logic [NBUF-1:0] txdone;
    logic [NBUF-1:0] txabrtd;
    logic            txtmo;

    modport master (
        output initreqr, txreq, txabort, tmo_limit, trans, sucftranc,
        input  traregbit, selbuf, selvalid, txpend, txdone, txabrtd, txtmo
    );

    modport slave (
        input  initreqr, txreq, txabort, tmo_limit, trans, sucftranc,
        output traregbit, selbuf, selvalid, txpend, txdone, txabrtd, txtmo
    );
endinterface

// File: rtl/llc_txsched.sv
// Transmit scheduler: keeps per-buffer pending bits, serves the lowest pending
// buffer through the LLC request/success handshake, reports done/abort/timeout.
module llc_txsched #(
    parameter int NBUF = 4,
    parameter int TMOW = 16
) (
    input  logic clock,
    input  logic reset,
    llc_txsched_if.slave bus
);
    localparam int SELW = $clog2(NBUF);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
    localparam logic [2:0] GAP  = 3'd4;
    localparam logic [2:0] TMO  = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [NBUF-1:0] pend_q, pend_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            abrtflag_q, abrtflag_d;
    logic [TMOW-1:0] tmocnt_q, tmocnt_d;
    logic [NBUF-1:0] txdone_q, txdone_d;
    logic [NBUF-1:0] txabrtd_q, txabrtd_d;
    logic            txtmo_q, txtmo_d;

    logic            inflight;
    logic            success;
    logic            tmo_hit;
    logic            tmo_abort;
    logic [TMOW-1:0] tmocnt_inc;
    logic [NBUF-1:0] sel_oh;
    logic [NBUF-1:0] cand;
    logic [SELW-1:0] cand_idx;

    // Buffers aborted in the same cycle are not eligible for selection.
    always_comb begin
        cand     = pend_q & ~bus.txabort;
        cand_idx = '0;
        for (int i = NBUF - 1; i >= 0; i--) begin
            if (cand[i]) begin
                cand_idx = SELW'(i);
            end
        end
    end

    assign inflight   = (state_q == REQ) || (state_q == WAIT);
    assign success    = (state_q == WAIT) && bus.sucftranc;
    assign sel_oh     = NBUF'(1) << sel_q;
    assign tmocnt_inc = (&tmocnt_q) ? tmocnt_q : tmocnt_q + TMOW'(1);
    // Compare the incremented count so txtmo is high in the cycle tmocnt reaches the limit.
    assign tmo_hit    = inflight && !success && (bus.tmo_limit != '0) &&
                        (tmocnt_inc == bus.tmo_limit);
    assign tmo_abort  = tmo_hit && (abrtflag_q || bus.txabort[sel_q]);

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        sel_d      = sel_q;
        abrtflag_d = abrtflag_q;
        tmocnt_d   = tmocnt_q;
        txdone_d   = '0;
        txabrtd_d  = '0;
        txtmo_d    = 1'b0;

        if (bus.initreqr) begin
            state_d    = IDLE;
            pend_d     = '0;
            abrtflag_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cand != '0) begin
                        state_d    = REQ;
                        sel_d      = cand_idx;
                        abrtflag_d = 1'b0;
                        tmocnt_d   = '0;
                    end
                end
                REQ: begin
                    tmocnt_d = tmocnt_inc;
                    if (tmo_hit) begin
                        state_d = TMO;
                    end else if (bus.trans) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    tmocnt_d = tmocnt_inc;
                    if (success) begin
                        state_d = DONE;
                    end else if (tmo_hit) begin
                        state_d = TMO;
                    end
                end
                DONE: begin
                    state_d = GAP;
                end
                GAP, TMO: begin
                    if (!bus.trans) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (inflight && bus.txabort[sel_q]) begin
                abrtflag_d = 1'b1;
            end

            txdone_d = success ? sel_oh : '0;
            txtmo_d  = tmo_hit;

            // An in-flight abort of the selected buffer is deferred to the timeout path.
            for (int i = 0; i < NBUF; i++) begin
                if ((bus.txabort[i] && !(inflight && sel_oh[i])) ||
                    (tmo_abort && sel_oh[i])) begin
                    pend_d[i]    = 1'b0;
                    txabrtd_d[i] = 1'b1;
                end else if (bus.txreq[i]) begin
                    pend_d[i] = 1'b1;
                end else if (success && sel_oh[i]) begin
                    pend_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            sel_q      <= '0;
            abrtflag_q <= 1'b0;
            tmocnt_q   <= '0;
            txdone_q   <= '0;
            txabrtd_q  <= '0;
            txtmo_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            sel_q      <= sel_d;
            abrtflag_q <= abrtflag_d;
            tmocnt_q   <= tmocnt_d;
            txdone_q   <= txdone_d;
            txabrtd_q  <= txabrtd_d;
            txtmo_q    <= txtmo_d;
        end
    end

    assign bus.traregbit = (state_q == REQ);
    assign bus.selbuf    = sel_q;
    assign bus.selvalid  = (state_q != IDLE);
    assign bus.txpend    = pend_q;
    assign bus.txdone    = txdone_q;
    assign bus.txabrtd   = txabrtd_q;
    assign bus.txtmo     = txtmo_q;
endmodule

// File: tb/tb_llc_txsched.sv
// Testbench for llc_txsched: directed scenarios plus random traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_llc_txsched;
    localparam int NBUF   = 4;
    localparam int TMOW   = 16;
    localparam int MAXCNT = (1 << TMOW) - 1;

    typedef enum int {M_IDLE, M_ASK, M_SENDING, M_SENT, M_DRAIN, M_EXPIRED} phase_t;

    logic clock = 1'b0;
    logic reset;

    llc_txsched_if #(.NBUF(NBUF), .TMOW(TMOW)) bus ();

    llc_txsched #(.NBUF(NBUF), .TMOW(TMOW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int nChecks = 0;
    int nPass   = 0;

    phase_t          mPhase;
    logic [NBUF-1:0] mPend, mDone, mAbrt;
    int              mSel, mAge;
    bit              mFlag, mTmo;

    logic [TMOW-1:0] curLimit;
    logic [NBUF-1:0] rndReq, rndAbort;
    logic            transHeld;
    int              tmoAt;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = M_IDLE;
        mPend  = '0;
        mDone  = '0;
        mAbrt  = '0;
        mSel   = 0;
        mAge   = 0;
        mFlag  = 1'b0;
        mTmo   = 1'b0;
    endtask

    // One clock edge of the reference: consumes the inputs sampled at that edge.
    task automatic modelStep();
        logic [NBUF-1:0] pendNext;
        bit busy, sent, expired, dropSel;
        int newAge, pick;
        mDone = '0;
        mAbrt = '0;
        mTmo  = 1'b0;
        if (bus.initreqr) begin
            mPend  = '0;
            mFlag  = 1'b0;
            mPhase = M_IDLE;
            return;
        end
        busy    = (mPhase == M_ASK) || (mPhase == M_SENDING);
        newAge  = (mAge < MAXCNT) ? mAge + 1 : mAge;
        sent    = (mPhase == M_SENDING) && bus.sucftranc;
        expired = busy && !sent && (bus.tmo_limit != 0) && (newAge == int'(bus.tmo_limit));
        dropSel = expired && (mFlag || bus.txabort[mSel]);
        pendNext = mPend;
        for (int i = 0; i < NBUF; i++) begin
            if ((bus.txabort[i] && !(busy && i == mSel)) || (dropSel && i == mSel)) begin
                pendNext[i] = 1'b0;
                mAbrt[i]    = 1'b1;
            end else if (bus.txreq[i]) begin
                pendNext[i] = 1'b1;
            end else if (sent && i == mSel) begin
                pendNext[i] = 1'b0;
            end
        end
        if (sent) mDone[mSel] = 1'b1;
        mTmo = expired;
        if (busy && bus.txabort[mSel]) mFlag = 1'b1;
        case (mPhase)
            M_IDLE: begin
                pick = -1;
                for (int i = NBUF - 1; i >= 0; i--) begin
                    if (mPend[i] && !bus.txabort[i]) pick = i;
                end
                if (pick >= 0) begin
                    mSel   = pick;
                    mFlag  = 1'b0;
                    mAge   = 0;
                    mPhase = M_ASK;
                end
            end
            M_ASK: begin
                mAge = newAge;
                if (expired) mPhase = M_EXPIRED;
                else if (bus.trans) mPhase = M_SENDING;
            end
            M_SENDING: begin
                mAge = newAge;
                if (sent) mPhase = M_SENT;
                else if (expired) mPhase = M_EXPIRED;
            end
            M_SENT: mPhase = M_DRAIN;
            default: if (!bus.trans) mPhase = M_IDLE;
        endcase
        mPend = pendNext;
    endtask

    task automatic checkAll();
        checkOutput("traregbit", 32'(bus.traregbit), 32'(mPhase == M_ASK));
        checkOutput("selvalid",  32'(bus.selvalid),  32'(mPhase != M_IDLE));
        checkOutput("selbuf",    32'(bus.selbuf),    32'(mSel));
        checkOutput("txpend",    32'(bus.txpend),    32'(mPend));
        checkOutput("txdone",    32'(bus.txdone),    32'(mDone));
        checkOutput("txabrtd",   32'(bus.txabrtd),   32'(mAbrt));
        checkOutput("txtmo",     32'(bus.txtmo),     32'(mTmo));
    endtask

    // Drive one cycle of inputs, check at the falling edge, advance the model at the rising edge.
    task automatic applyStimulus(input logic init, input logic [NBUF-1:0] req,
                                 input logic [NBUF-1:0] abort, input logic tr, input logic suc);
        bus.initreqr  = init;
        bus.txreq     = req;
        bus.txabort   = abort;
        bus.tmo_limit = curLimit;
        bus.trans     = tr;
        bus.sucftranc = suc;
        @(negedge clock);
        checkAll();
        @(posedge clock);
        modelStep();
        #1;
    endtask

    task automatic idleCycles(input int n, input logic tr);
        repeat (n) applyStimulus(1'b0, '0, '0, tr, 1'b0);
    endtask

    initial begin
        curLimit = '0;
        reset    = 1'b1;
        bus.initreqr = 1'b0; bus.txreq = '0; bus.txabort = '0;
        bus.tmo_limit = '0; bus.trans = 1'b0; bus.sucftranc = 1'b0;
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkAll();
        reset = 1'b0;

        // Single request through the full handshake
        applyStimulus(1'b0, 4'b0001, '0, 1'b0, 1'b0);
        idleCycles(1, 1'b0);
        checkOutput("single_traregbit", 32'(bus.traregbit), 32'd1);
        idleCycles(2, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        checkOutput("single_txdone", 32'(bus.txdone), 32'h1);
        idleCycles(1, 1'b1);
        idleCycles(3, 1'b0);

        // Priority: 1 before 3; request 0 during buffer 1's WAIT does not preempt
        applyStimulus(1'b0, 4'b1010, '0, 1'b0, 1'b0);
        idleCycles(1, 1'b0);
        checkOutput("prio_first_sel", 32'(bus.selbuf), 32'd1);
        idleCycles(1, 1'b1);
        applyStimulus(1'b0, 4'b0001, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        idleCycles(1, 1'b1);
        idleCycles(2, 1'b0);
        checkOutput("prio_second_sel", 32'(bus.selbuf), 32'd0);
        idleCycles(1, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        idleCycles(1, 1'b1);
        idleCycles(2, 1'b0);
        checkOutput("prio_third_sel", 32'(bus.selbuf), 32'd3);
        idleCycles(1, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        idleCycles(1, 1'b1);
        idleCycles(3, 1'b0);

        // Abort of a pending, non-selected buffer; then req+abort in one cycle
        applyStimulus(1'b0, 4'b0101, '0, 1'b0, 1'b0);
        idleCycles(1, 1'b0);
        applyStimulus(1'b0, '0, 4'b0100, 1'b0, 1'b0);
        checkOutput("abort_pulse", 32'(bus.txabrtd), 32'h4);
        idleCycles(1, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
        idleCycles(1, 1'b1);
        idleCycles(3, 1'b0);
        applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0);
        checkOutput("req_abort_same", 32'(bus.txpend[2]), 32'd0);
        idleCycles(2, 1'b0);

        // In-flight abort followed by timeout at limit 10
        curLimit = 16'd10;
        applyStimulus(1'b0, 4'b0001, '0, 1'b0, 1'b0);
        idleCycles(1, 1'b0);
        tmoAt = -1;
        for (int k = 1; k <= 14; k++) begin
            applyStimulus(1'b0, '0, (k == 1) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
            if (bus.txtmo && tmoAt < 0) tmoAt = k;
        end
        checkOutput("tmo_latency", 32'(tmoAt), 32'd10);
        checkOutput("tmo_abort_clears", 32'(bus.txpend[0]), 32'd0);

        // Timeout without abort: buffer stays pending and is retried
        applyStimulus(1'b0, 4'b0001, '0, 1'b0, 1'b0);
        idleCycles(30, 1'b0);
        checkOutput("tmo_retry_pend", 32'(bus.txpend[0]), 32'd1);
        applyStimulus(1'b1, '0, '0, 1'b0, 1'b0);
        curLimit = '0;
        idleCycles(2, 1'b0);

        // Init request in WAIT with all buffers pending
        applyStimulus(1'b0, 4'b1111, '0, 1'b0, 1'b0);
        idleCycles(1, 1'b0);
        idleCycles(2, 1'b1);
        applyStimulus(1'b1, '0, '0, 1'b1, 1'b1);
        checkOutput("init_txpend", 32'(bus.txpend), 32'h0);
        checkOutput("init_traregbit", 32'(bus.traregbit), 32'd0);
        idleCycles(2, 1'b0);

        // Asynchronous reset while in REQ
        applyStimulus(1'b0, 4'b0001, '0, 1'b0, 1'b0);
        idleCycles(1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_traregbit", 32'(bus.traregbit), 32'd0);
        checkOutput("async_selvalid", 32'(bus.selvalid), 32'd0);
        checkOutput("async_txpend", 32'(bus.txpend), 32'h0);
        modelReset();
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Random traffic
        transHeld = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0: curLimit = 16'd0;
                    1: curLimit = 16'd4;
                    2: curLimit = 16'd9;
                    default: curLimit = 16'd15;
                endcase
            end
            for (int b = 0; b < NBUF; b++) begin
                rndReq[b]   = ($urandom_range(0, 9) == 0);
                rndAbort[b] = ($urandom_range(0, 39) == 0);
            end
            if ($urandom_range(0, 3) == 0) transHeld = ~transHeld;
            applyStimulus(($urandom_range(0, 149) == 0), rndReq, rndAbort, transHeld,
                          ($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/llc_txsched.md
# llc_txsched

Transmit scheduler in front of the LLC FSM. Holds one pending-request bit per transmit buffer and picks the lowest-index pending buffer. Drives `traregbit` into the LLC and tracks the LLC handshake (`trans`, `sucftranc`) through to completion. Reports per-buffer done, abort and timeout status to the register block. It sits between the CPU register interface and the LLC FSM, and its select output steers the transmit-register mux.

## Interface
Parameters:
- `NBUF`, 4: number of transmit buffers (2..8).
- `TMOW`, 16: width of the timeout counter and of `tmo_limit`.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `initreqr`  in  1  CPU init request; synchronous flush.
- `txreq`  in  NBUF  one-cycle pulse per buffer; sets that buffer's pending bit.
- `txabort`  in  NBUF  one-cycle pulse per buffer; cancels that buffer's request.
- `tmo_limit`  in  TMOW  timeout in cycles; 0 disables the timeout.
- `trans`  in  1  from LLC; high while the LLC waits for transmit success.
- `sucftranc`  in  1  from MAC; successful-transmission pulse.
- `traregbit`  out  1  transmit request to the LLC.
- `selbuf`  out  clog2(NBUF)  index of the selected buffer (drives the tx-register mux).
- `selvalid`  out  1  `selbuf` is valid (every state except IDLE).
- `txpend`  out  NBUF  pending bits.
- `txdone`  out  NBUF  one-cycle success pulse.
- `txabrtd`  out  NBUF  one-cycle aborted pulse.
- `txtmo`  out  1  one-cycle timeout pulse.

## Operation
- Registers: state, `pend[NBUF]`, `sel`, `abrtflag`, `tmocnt[TMOW]`.
- Reset values: every register and output is 0, and state is IDLE.
- States and transitions:
  - IDLE: if `pend` is nonzero, latch `sel` = lowest set index, clear `abrtflag`, clear `tmocnt`, go to REQ.
  - REQ: `traregbit`=1. If `trans`=1, go to WAIT.
  - WAIT: `traregbit`=0. If `sucftranc`=1, go to DONE.
  - DONE: one cycle. `txdone[sel]`=1, then go to GAP.
  - GAP: wait for `trans`=0, then go to IDLE.
  - TMO: `traregbit`=0. Wait for `trans`=0, then go to IDLE.
- Timeout:
  - `tmocnt` increments each cycle in REQ and WAIT and saturates at its maximum.
  - If `tmo_limit` is nonzero and `tmocnt` equals `tmo_limit`, go to TMO and pulse `txtmo`.
  - If `abrtflag` is set at that point, clear `pend[sel]` and pulse `txabrtd[sel]`. Otherwise `pend[sel]` stays set and the buffer is retried.
- Pending-bit update, per bit, in priority order:
  1. `initreqr` clears the bit.
  2. An abort of a non-selected buffer, or any abort while in IDLE, clears the bit and pulses `txabrtd[i]`.
  3. `txreq[i]` sets the bit.
  4. Entering DONE clears `pend[sel]`.
- Abort of the selected buffer in REQ or WAIT sets `abrtflag`; the pending bit is not cleared yet.
  - On success, `txdone` pulses and `txabrtd` does not (the frame was sent).
- `txreq` and `txabort` on the same buffer in the same cycle: abort wins, and the bit ends up clear.
- `txreq` to a buffer that is already pending: no effect.
- `sucftranc` outside WAIT is ignored.
- `initreqr` in any state:
  - next state is IDLE;
  - all `pend` bits clear and `abrtflag` clears;
  - no done or abort pulses are generated;
  - `traregbit` drops on the next edge.
- `sel` is held constant from IDLE exit until the block returns to IDLE. A later higher-priority request does not preempt it.

## Timing
- All outputs are registered or decoded directly from state, so there is no combinational path from any input to `traregbit`.
- `txreq` at edge n sets `txpend` at n+1. With the block idle, state is REQ and `traregbit`=1 from edge n+2.
- `traregbit` falls on the edge after `trans` is first sampled high.
- `sucftranc` sampled at edge k: `txdone[sel]` is high during cycle k+1 and `txpend[sel]` is clear from k+1.
- Minimum turnaround, back to IDLE: 2 cycles after DONE if `trans` is already 0. The next request can be issued one cycle later.
- Timeout fires on the cycle `tmocnt` reaches `tmo_limit`, counted from REQ entry. REQ entry counts as cycle 0.
- Reset is asynchronous on assertion; release is synchronised outside this block.

## Test plan
- Single request: `txreq`=0001. Check `traregbit`=1 two cycles later; hold `trans`=1 → `traregbit`=0; pulse `sucftranc` → `txdone`=0001 for one cycle and `txpend`=0000; drop `trans` → IDLE.
- Priority: pulse `txreq`=1010 in one cycle. Check `selbuf`=1 is served first, then `selbuf`=3. Also assert `txreq[0]` during buffer 1's WAIT: buffer 1 completes before buffer 0 is selected.
- Abort:
  - abort buffer 2 while pending and not selected → `txabrtd`=0100 next cycle, never selected;
  - `txreq[2]` and `txabort[2]` in the same cycle → `txpend[2]`=0.
- In-flight abort and timeout: `tmo_limit`=10, LLC never raises `trans`, `txabort[0]` in REQ. Check `txtmo` and `txabrtd[0]` pulse 10 cycles after REQ entry and `pend[0]` clears. Repeat without the abort: `pend[0]` stays set and the buffer is re-requested after `trans`=0.
- Init and reset:
  - `initreqr` in WAIT with `txpend`=1111 → `txpend`=0000, `traregbit`=0, no pulses;
  - assert `reset` mid-REQ → all outputs 0 immediately, with no clock edge.
